// File: rtl/fir_ctrl_pkg.sv
// Shared state encoding and sizing helper for the fir controller.
package fir_ctrl_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ceiling log2 with a floor of 1 so single-bit counters stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Double-buffered coefficient storage: shadow written by config, active copied on swap.
module fir_coeff_bank #(
    parameter int COEFF_WIDTH = 8,
    parameter int NUM_TAPS    = 4,
    parameter int ADDR_WIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [COEFF_WIDTH-1:0]        wr_data,
    input  logic                          swap,
    output logic [COEFF_WIDTH*NUM_TAPS-1:0] coeff
);

    logic [COEFF_WIDTH-1:0] shadow [NUM_TAPS];
    logic [COEFF_WIDTH-1:0] active [NUM_TAPS];

    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow[gi] <= '0;
                    active[gi] <= '0;
                end else begin
                    if (wr_en && (wr_addr == ADDR_WIDTH'(gi))) begin
                        shadow[gi] <= wr_data;
                    end
                    if (swap) begin
                        active[gi] <= shadow[gi];
                    end
                end
            end

            assign coeff[COEFF_WIDTH*gi +: COEFF_WIDTH] = active[gi];
        end
    endgenerate

endmodule

// File: rtl/fir_ctrl.sv
// Commit handshake, pipeline refill tracking and decimation strobe for the fir datapath.
module fir_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int COEFF_WIDTH = 8,
    parameter int NUM_TAPS    = 4,
    parameter int DECIM_WIDTH = 8,
    parameter int ADDR_WIDTH  = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_wr_en,
    input  logic [ADDR_WIDTH-1:0]           cfg_addr,
    input  logic [COEFF_WIDTH-1:0]          cfg_wr_data,
    input  logic                            cfg_commit,
    input  logic [DECIM_WIDTH-1:0]          decim_ratio,
    output logic                            cfg_busy,
    input  logic                            in_valid,
    output logic [COEFF_WIDTH*NUM_TAPS-1:0] coeff,
    output logic                            out_valid
);

    localparam int CNT_W = clog2(NUM_TAPS);

    state_t                 state;
    logic                   pending;
    logic [CNT_W-1:0]       fill_cnt;
    logic [DECIM_WIDTH-1:0] phase;
    logic [DECIM_WIDTH-1:0] ratio;
    logic                   wr_ok;

    assign wr_ok = cfg_wr_en && !cfg_busy && (int'(cfg_addr) < NUM_TAPS);

    fir_coeff_bank #(
        .COEFF_WIDTH (COEFF_WIDTH),
        .NUM_TAPS    (NUM_TAPS),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok),
        .wr_addr (cfg_addr),
        .wr_data (cfg_wr_data),
        .swap    (pending),
        .coeff   (coeff)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            pending   <= 1'b0;
            cfg_busy  <= 1'b0;
            fill_cnt  <= '0;
            phase     <= '0;
            ratio     <= DECIM_WIDTH'(1);
            out_valid <= 1'b0;
        end else if (pending) begin
            // Swap edge: any sample arriving now is dropped and refill restarts.
            pending   <= 1'b0;
            cfg_busy  <= 1'b0;
            ratio     <= (decim_ratio == '0) ? DECIM_WIDTH'(1) : decim_ratio;
            state     <= ST_FILL;
            fill_cnt  <= '0;
            phase     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (cfg_commit && !cfg_busy) begin
                pending  <= 1'b1;
                cfg_busy <= 1'b1;
            end
            out_valid <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (in_valid) begin
                        if (fill_cnt == CNT_W'(NUM_TAPS - 2)) begin
                            state <= ST_RUN;
                        end else begin
                            fill_cnt <= fill_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        out_valid <= (phase == '0);
                        phase     <= (phase == ratio - DECIM_WIDTH'(1)) ? '0
                                                                        : phase + DECIM_WIDTH'(1);
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_ctrl.sv
// Scoreboard bench for fir_ctrl: a sample-count model predicts coeff, cfg_busy and out_valid.
module tb_fir_ctrl;

    localparam int CW = 8;
    localparam int NT = 4;
    localparam int DW = 8;
    localparam int AW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cfg_wr_en = 1'b0;
    logic [AW-1:0]        cfg_addr = '0;
    logic [CW-1:0]        cfg_wr_data = '0;
    logic                 cfg_commit = 1'b0;
    logic [DW-1:0]        decim_ratio = '0;
    logic                 cfg_busy;
    logic                 in_valid = 1'b0;
    logic [CW*NT-1:0]     coeff;
    logic                 out_valid;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [CW-1:0] m_shadow [NT];
    logic [CW-1:0] m_active [NT];
    bit            m_pending;
    int            m_ratio;
    int            m_cnt;

    bit            q_out   [$];
    bit            q_busy  [$];
    logic [CW*NT-1:0] q_coeff [$];

    always #5 clk = ~clk;

    fir_ctrl #(
        .COEFF_WIDTH (CW),
        .NUM_TAPS    (NT),
        .DECIM_WIDTH (DW),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_addr    (cfg_addr),
        .cfg_wr_data (cfg_wr_data),
        .cfg_commit  (cfg_commit),
        .decim_ratio (decim_ratio),
        .cfg_busy    (cfg_busy),
        .in_valid    (in_valid),
        .coeff       (coeff),
        .out_valid   (out_valid)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_pending = 1'b0;
        m_ratio   = 1;
        m_cnt     = 0;
    endtask

    function automatic logic [CW*NT-1:0] pack_active();
        logic [CW*NT-1:0] v;
        for (int i = 0; i < NT; i++) v[CW*i +: CW] = m_active[i];
        return v;
    endfunction

    // Evaluate the model for the upcoming edge using the inputs currently driven.
    task automatic model_edge();
        bit exp_out;
        exp_out = 1'b0;
        if (m_pending) begin
            for (int i = 0; i < NT; i++) m_active[i] = m_shadow[i];
            m_ratio   = (decim_ratio == 0) ? 1 : int'(decim_ratio);
            m_cnt     = 0;
            m_pending = 1'b0;
        end else begin
            if (cfg_wr_en && int'(cfg_addr) < NT) m_shadow[cfg_addr] = cfg_wr_data;
            if (cfg_commit) m_pending = 1'b1;
            if (in_valid) begin
                m_cnt++;
                exp_out = (m_cnt >= NT) && (((m_cnt - NT) % m_ratio) == 0);
            end
        end
        q_out.push_back(exp_out);
        q_busy.push_back(m_pending);
        q_coeff.push_back(pack_active());
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_val("out_valid", 32'(out_valid), 32'(q_out.pop_front()));
        check_val("cfg_busy",  32'(cfg_busy),  32'(q_busy.pop_front()));
        check_val("coeff",     coeff,          q_coeff.pop_front());
        $display("cyc t=%0t in_valid=%0b busy=%0b out_valid=%0b coeff=%h",
                 $time, in_valid, cfg_busy, out_valid, coeff);
    endtask

    task automatic write_tap(input int addr, input logic [CW-1:0] data);
        cfg_wr_en = 1'b1; cfg_addr = AW'(addr); cfg_wr_data = data;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic commit(input logic [DW-1:0] r);
        cfg_commit = 1'b1; decim_ratio = r;
        tick();
        cfg_commit = 1'b0;
        tick();
    endtask

    task automatic stream(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            in_valid = toggle ? ((i % 2) == 0) : 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check_val("rst_coeff", coeff, '0);
        check_val("rst_out",   32'(out_valid), 32'd0);
        check_val("rst_busy",  32'(cfg_busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ratio 1 after reset: first output after the 4th sample
        stream(7, 1'b0);

        // Load 01..04 and commit with ratio 3
        for (int i = 0; i < NT; i++) write_tap(i, CW'(i + 1));
        cfg_commit = 1'b1; decim_ratio = 8'd3;
        tick();
        check_val("busy_after_commit", 32'(cfg_busy), 32'd1);
        cfg_commit = 1'b0;
        tick();
        check_val("coeff_loaded", coeff, 32'h04030201);
        check_val("busy_one_cycle", 32'(cfg_busy), 32'd0);
        decim_ratio = 8'd5;   // ignored until next swap
        stream(13, 1'b0);

        // Write coincident with commit, then a write during busy that must drop
        cfg_wr_en = 1'b1; cfg_addr = 2'd2; cfg_wr_data = 8'h7F;
        cfg_commit = 1'b1; decim_ratio = 8'd0;
        tick();
        cfg_commit = 1'b0; cfg_addr = 2'd0; cfg_wr_data = 8'hAA;
        tick();
        cfg_wr_en = 1'b0;
        check_val("coeff_wr_commit", coeff, 32'h047F0201);
        stream(8, 1'b0);

        // Gapped stream with ratio 2
        commit(8'd2);
        stream(24, 1'b1);

        // Commit mid-stream with ratio 1, sample in swap cycle discarded
        commit(8'd1);
        in_valid = 1'b1;
        stream(4, 1'b0);
        in_valid = 1'b1; cfg_commit = 1'b1; decim_ratio = 8'd1;
        tick();
        cfg_commit = 1'b0;
        tick();
        stream(7, 1'b0);

        // Asynchronous reset mid-stream
        in_valid = 1'b1;
        write_tap(1, 8'h55);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_coeff", coeff, '0);
        check_val("mid_rst_out",   32'(out_valid), 32'd0);
        check_val("mid_rst_busy",  32'(cfg_busy), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        stream(7, 1'b0);

        // Shadow was cleared by reset: committing now must yield zeros
        commit(8'd1);
        check_val("shadow_cleared", coeff, '0);

        if (q_out.size() != 0) check_val("queue_drain", 32'(q_out.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
